snail_sequence_gen: RTL and testbench



---
 rtl/snail_sequence_gen_if.sv | 24 ++
 rtl/snail_sequence_gen.sv | 129 ++++++++++++
 tb/tb_snail_sequence_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/snail_sequence_gen_if.sv
// snail_sequence_gen_if: command handshake (start/pattern/length/repeat/ready) and serial outputs (sequence/valid/busy/done)
interface snail_sequence_gen_if #(
  parameter int WIDTH = 8,
  parameter int REPEAT_W = 4
);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  logic start_in;
  logic [WIDTH-1:0] pattern_in;
  logic [LEN_W-1:0] length_in;
  logic [REPEAT_W-1:0] repeat_in;
  logic ready_out;
  logic sequence_out;
  logic seq_valid_out;
  logic busy_out;
  logic done_out;
  modport master (
    output start_in, pattern_in, length_in, repeat_in,
    input ready_out, sequence_out, seq_valid_out, busy_out, done_out
  );
  modport slave (
    input start_in, pattern_in, length_in, repeat_in,
    output ready_out, sequence_out, seq_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/snail_sequence_gen.sv
// snail_sequence_gen: serial MSB-first pattern transmitter with repeats and gaps; ports clk_in, rst_in, bus (cmd in, registered serial/status out)
module snail_sequence_gen #(
  parameter int WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int REPEAT_W = 4
) (
  input logic clk_in,
  input logic rst_in,
  snail_sequence_gen_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] pat, pat_n;
  logic [LEN_W-1:0] len, len_n, idx, idx_n, len_c;
  logic [REPEAT_W-1:0] pass, pass_n;
  logic [GW-1:0] gap, gap_n;
  logic ready_r, seq_r, valid_r, busy_r, done_r;
  logic ready_n, seq_n, valid_n, busy_n, done_n;
  function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    return |(p & (WIDTH'(1) << i));
  endfunction
  always_comb begin
    state_n = state;
    pat_n = pat;
    len_n = len;
    idx_n = idx;
    pass_n = pass;
    gap_n = gap;
    ready_n = 1'b0;
    seq_n = 1'b0;
    valid_n = 1'b0;
    busy_n = 1'b1;
    done_n = 1'b0;
    len_c = bus.length_in > WMAX ? WMAX : bus.length_in;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        busy_n = 1'b0;
        if (bus.start_in) begin
          pat_n = bus.pattern_in;
          len_n = len_c;
          pass_n = bus.repeat_in;
          ready_n = 1'b0;
          busy_n = 1'b1;
          if (len_c == '0) begin
            state_n = DONE;
            done_n = 1'b1;
          end else begin
            state_n = SHIFT;
            idx_n = len_c - LEN_W'(1);
            seq_n = bit_at(bus.pattern_in, len_c - LEN_W'(1));
            valid_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (idx != '0) begin
          idx_n = idx - LEN_W'(1);
          seq_n = bit_at(pat, idx - LEN_W'(1));
          valid_n = 1'b1;
        end else if (pass == '0) begin
          state_n = DONE;
          done_n = 1'b1;
        end else begin
          pass_n = pass - REPEAT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n = GW'(GAP_CYCLES - 1);
          end else begin
            idx_n = len - LEN_W'(1);
            seq_n = bit_at(pat, len - LEN_W'(1));
            valid_n = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap != '0) begin
          gap_n = gap - GW'(1);
        end else begin
          state_n = SHIFT;
          idx_n = len - LEN_W'(1);
          seq_n = bit_at(pat, len - LEN_W'(1));
          valid_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        ready_n = 1'b1;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      pat <= '0;
      len <= '0;
      idx <= '0;
      pass <= '0;
      gap <= '0;
      ready_r <= 1'b1;
      seq_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state <= state_n;
      pat <= pat_n;
      len <= len_n;
      idx <= idx_n;
      pass <= pass_n;
      gap <= gap_n;
      ready_r <= ready_n;
      seq_r <= seq_n;
      valid_r <= valid_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end
  assign bus.ready_out = ready_r;
  assign bus.sequence_out = seq_r;
  assign bus.seq_valid_out = valid_r;
  assign bus.busy_out = busy_r;
  assign bus.done_out = done_r;
endmodule

// File: tb/tb_snail_sequence_gen.sv
// tb_snail_sequence_gen: directed and random commands checked against a per-cycle expected trace
module tb_snail_sequence_gen;
  localparam int WIDTH = 8;
  localparam int GAP = 2;
  localparam int RW = 4;
  localparam int LW = $clog2(WIDTH) + 1;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];
  snail_sequence_gen_if #(.WIDTH(WIDTH), .REPEAT_W(RW)) bus ();
  snail_sequence_gen #(.WIDTH(WIDTH), .GAP_CYCLES(GAP), .REPEAT_W(RW)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [4:0] outs();
    return {bus.ready_out, bus.sequence_out, bus.seq_valid_out, bus.busy_out, bus.done_out};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic build(input logic [7:0] p, input int len, input int rep);
    int l = len > WIDTH ? WIDTH : len;
    exp_q.delete();
    if (l > 0)
      for (int k = 0; k <= rep; k++) begin
        for (int b = l - 1; b >= 0; b--) exp_q.push_back({1'b0, p[b], 1'b1, 1'b1, 1'b0});
        if (k < rep) for (int g = 0; g < GAP; g++) exp_q.push_back(5'b00010);
      end
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b10000);
  endtask
  task automatic run_cmd(input string tag, input logic [7:0] p, input int len, input int rep, input int poke);
    int w = 0;
    while (bus.ready_out !== 1'b1 && w < 400) begin
      @(negedge clk_in);
      w++;
    end
    if (w == 400) chk({tag, "_ready_timeout"}, 0, 1);
    build(p, len, rep);
    bus.start_in = 1'b1;
    bus.pattern_in = p;
    bus.length_in = LW'(len);
    bus.repeat_in = RW'(rep);
    @(posedge clk_in);
    #1;
    bus.start_in = 1'b0;
    bus.pattern_in = 8'($urandom);
    bus.length_in = LW'($urandom);
    bus.repeat_in = RW'($urandom);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk_in);
      chk($sformatf("%s_c%0d", tag, c + 1), 32'(outs()), 32'(exp_q[c]));
      if (c + 1 == poke) begin
        bus.start_in = 1'b1;
        bus.pattern_in = ~p;
        bus.length_in = LW'(WIDTH);
        bus.repeat_in = '0;
        @(posedge clk_in);
        #1;
        bus.start_in = 1'b0;
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start_in = 1'b0;
    bus.pattern_in = '0;
    bus.length_in = '0;
    bus.repeat_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset", 32'(outs()), 32'h10);
    run_cmd("single", 8'h0D, 4, 0, 0);
    run_cmd("repeat3", 8'h0D, 4, 2, 0);
    run_cmd("len0", 8'h3C, 0, 5, 0);
    run_cmd("clamp", 8'hA5, 12, 0, 0);
    run_cmd("ignore_start", 8'h96, 8, 1, 3);
    run_cmd("rep_max", 8'h5B, 3, 15, 0);
    run_cmd("len1", 8'h01, 1, 3, 0);
    bus.start_in = 1'b1;
    bus.pattern_in = 8'hC3;
    bus.length_in = LW'(8);
    bus.repeat_in = RW'(1);
    @(posedge clk_in);
    #1;
    bus.start_in = 1'b0;
    @(negedge clk_in);
    chk("abort_b1", 32'(outs()), 32'h0E);
    @(negedge clk_in);
    chk("abort_b2", 32'(outs()), 32'h0E);
    @(negedge clk_in);
    chk("abort_b3", 32'(outs()), 32'h06);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk($sformatf("abort_idle%0d", i), 32'(outs()), 32'h10);
    end
    bus.start_in = 1'b1;
    bus.length_in = LW'(4);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    bus.start_in = 1'b0;
    @(negedge clk_in);
    chk("rst_prio", 32'(outs()), 32'h10);
    run_cmd("after_abort", 8'h81, 8, 0, 0);
    for (int t = 0; t < 30; t++) begin
      int len = $urandom_range(0, 15);
      int rep = $urandom_range(0, 15);
      int poke = (len > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
      run_cmd($sformatf("rnd%0d", t), 8'($urandom), len, rep, poke);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
